// File: rtl/arith_unit_mc.sv
// Multi-cycle unsigned arithmetic unit: 1-cycle add/sub/mul, restoring divider
// producing quotient (low A_width bits) and remainder (high B_width bits).
module arith_unit_mc #(
  parameter int A_width = 16,
  parameter int B_width = 16
) (
  input  logic                       CLK_ARITH,
  input  logic                       RST_ARITH,
  input  logic [A_width-1:0]         A_IN_ARITH,
  input  logic [B_width-1:0]         B_IN_ARITH,
  input  logic [1:0]                 ALU_FUN_ARITH,
  input  logic                       ARITH_EN,
  output logic                       ARITH_BUSY,
  output logic                       ARITH_FLAG,
  output logic [A_width+B_width-1:0] ARITH_OUT,
  output logic                       Carry_out,
  output logic                       Zero_flag,
  output logic                       Div_by_zero
);
  localparam int ARITH_OUT_width = A_width + B_width;
  localparam int CNT_width       = $clog2(A_width + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t                     state_q;
  logic [CNT_width-1:0]       cnt_q;
  logic [A_width-1:0]         dvd_q;   // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [B_width-1:0]         dvs_q;
  logic [B_width-1:0]         rem_q;
  logic [ARITH_OUT_width-1:0] out_q;
  logic                       flag_q, busy_q, carry_q, zero_q, dbz_q;

  logic [ARITH_OUT_width-1:0] a_ext, b_ext, sum_w, diff_w, prod_w;
  logic [ARITH_OUT_width-1:0] op_out_d;
  logic                       op_carry_d, op_dbz_d, div_start;

  assign a_ext  = ARITH_OUT_width'(A_IN_ARITH);
  assign b_ext  = ARITH_OUT_width'(B_IN_ARITH);
  assign sum_w  = a_ext + b_ext;
  assign diff_w = a_ext - b_ext;
  assign prod_w = a_ext * b_ext;

  assign div_start = (ALU_FUN_ARITH == 2'b11) && (B_IN_ARITH != '0);

  always_comb begin
    op_out_d   = '0;
    op_carry_d = 1'b0;
    op_dbz_d   = 1'b0;
    case (ALU_FUN_ARITH)
      2'b00: begin
        op_out_d   = sum_w;
        op_carry_d = sum_w[A_width];
      end
      2'b01: begin
        op_out_d   = diff_w;
        op_carry_d = (a_ext < b_ext);
      end
      2'b10: op_out_d = prod_w;
      // Only reached with B == 0; nonzero divisors take the iterative path.
      default: begin
        op_out_d = {A_IN_ARITH[B_width-1:0], {A_width{1'b1}}};
        op_dbz_d = 1'b1;
      end
    endcase
  end

  // One restoring step; the remainder stays below the divisor so B_width bits suffice.
  logic [B_width:0]           shifted_w;
  logic                       ge_w;
  logic [B_width-1:0]         rem_nx;
  logic [A_width-1:0]         quo_nx;
  logic [ARITH_OUT_width-1:0] div_out_d;

  assign shifted_w = {rem_q, dvd_q[A_width-1]};
  assign ge_w      = (shifted_w >= {1'b0, dvs_q});
  assign rem_nx    = ge_w ? (shifted_w[B_width-1:0] - dvs_q) : shifted_w[B_width-1:0];
  assign quo_nx    = {dvd_q[A_width-2:0], ge_w};
  assign div_out_d = {rem_nx, quo_nx};

  always_ff @(posedge CLK_ARITH or negedge RST_ARITH) begin
    if (!RST_ARITH) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ARITH_EN) begin
            if (div_start) begin
              dvd_q   <= A_IN_ARITH;
              dvs_q   <= B_IN_ARITH;
              rem_q   <= '0;
              cnt_q   <= CNT_width'(A_width);
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= DIV;
            end else begin
              out_q   <= op_out_d;
              carry_q <= op_carry_d;
              zero_q  <= (op_out_d == '0);
              dbz_q   <= op_dbz_d;
              flag_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q - CNT_width'(1);
          if (cnt_q == CNT_width'(1)) begin
            out_q   <= div_out_d;
            carry_q <= 1'b0;
            zero_q  <= (div_out_d == '0);
            flag_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARITH_BUSY  = busy_q;
  assign ARITH_FLAG  = flag_q;
  assign ARITH_OUT   = out_q;
  assign Carry_out   = carry_q;
  assign Zero_flag   = zero_q;
  assign Div_by_zero = dbz_q;
endmodule

// File: tb/tb_arith_unit_mc.sv
// Directed bench for arith_unit_mc: hand-computed vectors, immediate assertions.
module tb_arith_unit_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic [1:0]  fun;
  logic        en;
  logic        busy, flag, carry, zero, dbz;
  logic [31:0] out;
  int          checks = 0;
  int          errors = 0;
  int          cycles;

  arith_unit_mc #(.A_width(16), .B_width(16)) dut (
    .CLK_ARITH    (clk),
    .RST_ARITH    (rst_n),
    .A_IN_ARITH   (a),
    .B_IN_ARITH   (b),
    .ALU_FUN_ARITH(fun),
    .ARITH_EN     (en),
    .ARITH_BUSY   (busy),
    .ARITH_FLAG   (flag),
    .ARITH_OUT    (out),
    .Carry_out    (carry),
    .Zero_flag    (zero),
    .Div_by_zero  (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = '0; b = '0; fun = 2'b00;
    #2;
    chk("rst_out",  64'(out), 64'h0);
    chk("rst_flags", {59'h0, busy, flag, carry, zero, dbz}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // add with carry out of bit 16
    a = 16'hFFFF; b = 16'h0001; fun = 2'b00; en = 1'b1;
    tick(); en = 1'b0;
    chk("add_out", 64'(out), 64'h0001_0000);
    chk("add_flags", {60'h0, flag, carry, zero, busy}, {60'h0, 4'b1100});
    tick();
    chk("add_hold", {31'h0, flag, out}, {31'h0, 1'b0, 32'h0001_0000});

    // back-to-back subtracts
    a = 16'd5; b = 16'd7; fun = 2'b01; en = 1'b1;
    tick();
    chk("sub_borrow_out", 64'(out), 64'hFFFF_FFFE);
    chk("sub_borrow_flags", {61'h0, flag, carry, zero}, {61'h0, 3'b110});
    a = 16'd7; b = 16'd7;
    tick(); en = 1'b0;
    chk("sub_zero_out", 64'(out), 64'h0);
    chk("sub_zero_flags", {61'h0, flag, carry, zero}, {61'h0, 3'b101});

    // full-width multiply
    a = 16'hFFFF; b = 16'hFFFF; fun = 2'b10; en = 1'b1;
    tick(); en = 1'b0;
    chk("mul_out", 64'(out), 64'hFFFE_0001);
    chk("mul_flags", {60'h0, flag, carry, zero, busy}, {60'h0, 4'b1000});

    // divide 1000 / 7 = 142 r 6, with ignored requests while busy
    a = 16'd1000; b = 16'd7; fun = 2'b11; en = 1'b1;
    tick(); en = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      chk("div_no_flag_while_busy", 64'(flag), 64'h0);
      cycles++;
      if (cycles == 3) begin en = 1'b1; fun = 2'b00; a = 16'd1; b = 16'd2; end
      if (cycles == 4) begin en = 1'b0; a = 16'hDEAD; b = 16'h0000; fun = 2'b11; end
      if (cycles == 16) begin en = 1'b1; fun = 2'b00; a = 16'd2; b = 16'd3; end
      tick();
    end
    chk("div_busy_cycles", 64'(cycles), 64'd16);
    chk("div_out", 64'(out), {32'h0, 16'd6, 16'd142});
    chk("div_flags", {59'h0, flag, carry, zero, dbz, busy}, {59'h0, 5'b10000});
    // request held across the completion edge is taken one cycle later
    tick(); en = 1'b0;
    chk("post_div_add", {31'h0, flag, out}, {31'h0, 1'b1, 32'd5});
    tick();
    chk("post_div_idle", {62'h0, flag, busy}, 64'h0);

    // divide by zero
    a = 16'h1234; b = 16'h0000; fun = 2'b11; en = 1'b1;
    tick(); en = 1'b0;
    chk("dbz_out", 64'(out), 64'h1234_FFFF);
    chk("dbz_flags", {59'h0, flag, carry, zero, dbz, busy}, {59'h0, 5'b10010});
    tick();
    chk("dbz_hold", {62'h0, flag, dbz}, {62'h0, 2'b01});
    a = 16'd1; b = 16'd1; fun = 2'b00; en = 1'b1;
    tick(); en = 1'b0;
    chk("dbz_cleared", {31'h0, dbz, out}, {31'h0, 1'b0, 32'd2});

    // asynchronous reset in the middle of a divide
    a = 16'd1000; b = 16'd7; fun = 2'b11; en = 1'b1;
    tick(); en = 1'b0;
    repeat (8) tick();
    chk("mid_div_busy", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 64'(out), 64'h0);
    chk("async_rst_flags", {59'h0, busy, flag, carry, zero, dbz}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {62'h0, flag, busy}, 64'h0);
    a = 16'd3; b = 16'd4; fun = 2'b00; en = 1'b1;
    tick(); en = 1'b0;
    chk("post_rst_add", {30'h0, flag, busy, out}, {30'h0, 2'b10, 32'd7});
    repeat (20) begin
      tick();
      chk("post_rst_no_late_flag", {62'h0, flag, busy}, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arith_unit_mc.md
Name: arith_unit_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle arithmetic unit in the ALU datapath. Add, subtract and multiply complete in one cycle. Divide is a true sequential restoring divider that produces both quotient and remainder. The block adds a busy/valid handshake, held results and per-result status flags (carry/borrow, zero, divide-by-zero). It sits beside the logic/compare/shift units under the ALU top, driven by the ALU function decoder.

Parameters:
A_width, 16, width of operand A / dividend (unsigned); must be >= B_width
B_width, 16, width of operand B / divisor (unsigned); >= 2
ARITH_OUT_width, A_width+B_width, result width; derived, not overridable
CNT_width, clog2(A_width+1), iteration counter width; derived

Ports:
CLK_ARITH  in  1  clock, rising edge
RST_ARITH  in  1  asynchronous active-low reset
A_IN_ARITH  in  A_width  operand A
B_IN_ARITH  in  B_width  operand B
ALU_FUN_ARITH  in  2  00 add, 01 sub, 10 mul, 11 div
ARITH_EN  in  1  request; sampled only when ARITH_BUSY=0
ARITH_BUSY  out  1  divide in progress; new requests ignored
ARITH_FLAG  out  1  one-cycle pulse: new result valid on ARITH_OUT
ARITH_OUT  out  ARITH_OUT_width  result, held until next result
Carry_out  out  1  add carry / sub borrow; 0 for mul/div
Zero_flag  out  1  ARITH_OUT == 0
Div_by_zero  out  1  last division had B == 0

Behaviour:
- Reset (asynchronous, any time, including mid-divide): ARITH_OUT=0, ARITH_FLAG=0, ARITH_BUSY=0, Carry_out=0, Zero_flag=0, Div_by_zero=0. FSM goes to IDLE. Partial divide state is discarded.
- Accept edge: a rising edge with ARITH_EN=1 and ARITH_BUSY=0. ARITH_EN while busy is ignored; it is not queued.
- All arithmetic is unsigned. Operands are zero-extended to ARITH_OUT_width.
- Add: ARITH_OUT = A+B. Carry_out = sum bit max(A_width,B_width).
- Sub: ARITH_OUT = (A-B) mod 2^ARITH_OUT_width. Carry_out = 1 iff A<B (borrow).
- Mul: ARITH_OUT = A*B, full width, with no truncation. Carry_out=0.
- Add, sub and mul have latency 1. At the accept edge, ARITH_OUT and the flags are registered and ARITH_FLAG=1 for exactly the following cycle.
- Div with B != 0:
  - Accept edge: latch A and B, clear the partial remainder, set counter=A_width, go to DIV, ARITH_BUSY=1.
  - Each DIV edge performs one restoring step (shift in the next dividend MSB, trial-subtract B, set the quotient bit) and decrements the counter.
  - On the edge where the counter reaches 0, register the results, pulse ARITH_FLAG for one cycle and return to IDLE with ARITH_BUSY=0.
  - Result layout: ARITH_OUT[A_width-1:0]=quotient, ARITH_OUT[A_width+B_width-1:A_width]=remainder.
  - Total A_width cycles busy. ARITH_FLAG is high in the cycle after the A_width-th DIV edge.
- Div with B == 0: no iterations; latency 1 like add. Quotient=all ones, remainder=A[B_width-1:0], Div_by_zero=1, Carry_out=0, ARITH_FLAG pulses.
- Div_by_zero is cleared by the next accepted operation of any kind.
- Zero_flag is computed from the newly registered ARITH_OUT value.
- FSM states: IDLE (accepts requests) and DIV (iterating). Transitions: IDLE->DIV on accept with div and B!=0; DIV->IDLE when counter hits 0; any->IDLE on reset.
- Between results, ARITH_OUT and all flags hold. Deasserting ARITH_EN does not clear the output.
- Back-to-back: a request on the same edge that a divide completes is not accepted, because ARITH_BUSY is still 1 on that edge. A request in the next cycle is accepted. Single-cycle operations may be issued every cycle, giving one ARITH_FLAG pulse per cycle.
- Operand inputs may change freely while busy; the divider uses only its latched copies.

Test Plan:
1. Add: A=16'hFFFF, B=16'h0001, EN one cycle -> next cycle ARITH_FLAG=1, ARITH_OUT=32'h0001_0000, Carry_out=1, Zero_flag=0; output holds after EN drops.
2. Sub: A=5, B=7 -> ARITH_OUT=32'hFFFF_FFFE, Carry_out=1. Then A=7, B=7 -> ARITH_OUT=0, Zero_flag=1, Carry_out=0.
3. Mul: A=16'hFFFF, B=16'hFFFF -> ARITH_OUT=32'hFFFE_0001, Carry_out=0, latency 1.
4. Div: A=1000, B=7 -> ARITH_BUSY high for exactly 16 cycles, then a single ARITH_FLAG pulse with ARITH_OUT={16'd6,16'd142}. ARITH_EN pulses and operand changes during busy are ignored with no extra flag pulses.
5. Div by zero: A=16'h1234, B=0 -> 1-cycle latency, ARITH_OUT={16'h1234,16'hFFFF}, Div_by_zero=1, ARITH_BUSY never asserts. A following add clears Div_by_zero.
6. Reset mid-divide: assert RST_ARITH low at iteration 8 asynchronously -> all outputs 0 immediately, no FLAG. After release, a new add (3+4) gives ARITH_OUT=7 at latency 1.
